// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter: lock FSM states, port
//   indices and the GPIO addresses that data memory decodes.
//   No ports.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int P_CPU = 0;
  localparam int P_DBG = 1;

  localparam logic [31:0] GPIO_IN_ADDR  = 32'hFFFF_FFF8;
  localparam logic [31:0] GPIO_OUT_ADDR = 32'hFFFF_FFFC;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
//   Combinational 2-way picker. Returns a one-hot grant.
//   i_req      [1:0]  request per port (bit 0 = CPU, bit 1 = debug/DMA)
//   i_last_gnt        port granted most recently (round-robin tie break)
//   i_rr_mode         1 = round-robin, 0 = fixed priority to port 0
//   i_force1          fixed-priority starvation override, grants port 1 on a tie
//   o_gnt      [1:0]  one-hot grant, zero when nothing requests
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       i_req_0,
  input  logic       i_req_1,
  input  logic       i_last_gnt,
  input  logic       i_rr_mode,
  input  logic       i_force1,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_req_0 && i_req_1) begin
      if (i_rr_mode) begin
        // Tie goes to the port that did not win last time.
        o_gnt[P_CPU] = i_last_gnt;
        o_gnt[P_DBG] = ~i_last_gnt;
      end else if (i_force1) begin
        o_gnt[P_DBG] = 1'b1;
      end else begin
        o_gnt[P_CPU] = 1'b1;
      end
    end else if (i_req_0) begin
      o_gnt[P_CPU] = 1'b1;
    end else if (i_req_1) begin
      o_gnt[P_DBG] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the core LSU (port 0) and the
//   debug/DMA loader (port 1). One transaction per cycle, combinational grant,
//   registered read return one cycle later, lock for atomic sequences and a
//   starvation guard for port 1 in fixed-priority mode.
//   clk, rst_n                       clock, async active-low reset
//   m*_req/we/lock/addr/wdata        requester inputs, held until granted
//   m*_gnt                           grant, transaction completes this cycle
//   m*_rvalid/rdata                  registered read return
//   mem_we/re/addr/wdata, mem_rdata  data memory interface
//
// state | meaning
// ARB   | arbitrate between both ports each cycle
// LOCK0 | port 0 owns the memory, port 1 is ignored
// LOCK1 | port 1 owns the memory, port 0 is ignored
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int RR_MODE      = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] LP_STARVE_LIMIT = 8'(STARVE_LIMIT);
  localparam logic       LP_RR           = (RR_MODE != 0);

  arb_state_t        r_state;
  logic              r_last_gnt;
  logic [7:0]        r_starve_cnt;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic [1:0] w_pick;
  logic [1:0] w_gnt;
  logic       w_force1;

  assign w_force1 = !LP_RR && (r_starve_cnt == LP_STARVE_LIMIT);

  dmem_arb_pick u_pick (
    .i_req_0    (m0_req),
    .i_req_1    (m1_req),
    .i_last_gnt (r_last_gnt),
    .i_rr_mode  (LP_RR),
    .i_force1   (w_force1),
    .o_gnt      (w_pick)
  );

  // Grant is gated by rst_n so nothing reaches memory in a reset cycle.
  always_comb begin
    w_gnt = '0;
    if (rst_n) begin
      case (r_state)
        ARB:     w_gnt = w_pick;
        LOCK0:   w_gnt[P_CPU] = m0_req;
        LOCK1:   w_gnt[P_DBG] = m1_req;
        default: w_gnt = '0;
      endcase
    end
  end

  assign m0_gnt = w_gnt[P_CPU];
  assign m1_gnt = w_gnt[P_DBG];

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt[P_DBG]) begin
      mem_we    = m1_we;
      mem_re    = ~m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else if (w_gnt[P_CPU]) begin
      mem_we    = m0_we;
      mem_re    = ~m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end
  end

  // Lock release is evaluated every cycle, even without a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
    end else begin
      case (r_state)
        ARB: begin
          if (w_gnt[P_CPU] && m0_lock)      r_state <= LOCK0;
          else if (w_gnt[P_DBG] && m1_lock) r_state <= LOCK1;
        end
        LOCK0:   if (!m0_lock) r_state <= ARB;
        LOCK1:   if (!m1_lock) r_state <= ARB;
        default: r_state <= ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt   <= 1'b1;
      r_starve_cnt <= '0;
    end else begin
      if (w_gnt[P_DBG])      r_last_gnt <= 1'b1;
      else if (w_gnt[P_CPU]) r_last_gnt <= 1'b0;

      // Port 0 holding a lock takes precedence over the starvation guard.
      if (r_state != LOCK0) begin
        if (w_gnt[P_DBG] || !m1_req)
          r_starve_cnt <= '0;
        else if (w_gnt[P_CPU] && (r_starve_cnt != LP_STARVE_LIMIT))
          r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_gnt[P_CPU] && !m0_we;
      r_rvalid1 <= w_gnt[P_DBG] && !m1_we;
      if (w_gnt[P_CPU] && !m0_we) r_rdata0 <= mem_rdata;
      if (w_gnt[P_DBG] && !m1_we) r_rdata1 <= mem_rdata;
    end
  end

  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (1 KB word array plus GPIO at 0xFFFFFFF8/0xFFFFFFFC) between two requesters.
  - Port 0: the core's load/store unit.
  - Port 1: the debug/DMA loader.
- Grants one transaction per cycle and drives the memory's we/re/addr/data_w.
- Returns read data registered, one cycle after grant.
- Supports a lock for atomic multi-cycle sequences and a starvation guard for port 1.

Parameters:
- DATA_W, 32, data and address width.
- RR_MODE, 0, 0 = fixed priority to port 0 with starvation guard; 1 = round-robin.
- STARVE_LIMIT, 8, consecutive port-0 grants with m1_req pending before port 1 is forced (fixed-priority mode only; range 1..255).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req, m1_req  in  1  request; held with its attributes stable until the matching gnt.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_lock, m1_lock  in  1  hold ownership after this grant.
- m0_addr, m1_addr  in  DATA_W  byte address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_gnt, m1_gnt  out  1  combinational grant; the transaction completes this cycle.
- m0_rvalid, m1_rvalid  out  1  read data valid, one cycle after a granted read.
- m0_rdata, m1_rdata  out  DATA_W  registered read data.
- mem_we, mem_re  out  1  to data memory.
- mem_addr, mem_wdata  out  DATA_W  to data memory.
- mem_rdata  in  DATA_W  combinational read data from data memory.

Behaviour:
- Reset (async, rst_n low):
  - state = ARB, last_gnt = 1 (port 0 wins first round-robin tie), starve_cnt = 0.
  - m*_rvalid = 0, m*_rdata = 0.
  - While rst_n is low, gnt/mem_we/mem_re are forced to 0 combinationally, so no write is issued in the reset cycle.
- State ARB, pick:
  - Only one req high: grant it.
  - Both high, RR_MODE = 1: grant the port not equal to last_gnt.
  - Both high, RR_MODE = 0: grant port 0, unless starve_cnt == STARVE_LIMIT, then grant port 1.
- State LOCK0 / LOCK1:
  - Only the owning port may be granted; the other port's req is ignored (gnt = 0).
  - No grant is issued if the owner's req is low; ownership is still held.
- Transitions:
  - ARB -> LOCKn when port n is granted with mn_lock = 1.
  - LOCKn -> ARB on any cycle where mn_lock = 0; that cycle's grant, if any, is still served.
- Memory drive (same cycle as gnt):
  - mem_addr/mem_wdata come from the granted port.
  - mem_we = gnt & we; mem_re = gnt & ~we.
  - With no grant, all mem_* outputs are 0.
- Read return: at the posedge after a granted read, mn_rdata <= mem_rdata and mn_rvalid <= 1. mn_rvalid pulses for one cycle per read. rdata holds its value until the next read on that port.
- Writes complete at the posedge of the grant cycle; there is no response.
- last_gnt updates on every grant.
- starve_cnt:
  - Increments on a port-0 grant while m1_req = 1.
  - Clears on any port-1 grant or when m1_req = 0.
  - Saturates at STARVE_LIMIT.
  - Frozen during LOCK0 (lock overrides the starvation guard).
- Back-to-back: a port may be granted every cycle; a read followed by a read gives rvalid on consecutive cycles.
- Address decode (GPIO vs RAM) stays inside data memory. The arbiter passes the address unmodified and has no alignment check.
- Reset asserted mid-lock or mid-read: the pending rvalid is dropped and the state returns to ARB.

Decomposition:
- Package dmem_arb_pkg holds:
  - arb_state_t enum {ARB, LOCK0, LOCK1}.
  - Port index constants P_CPU = 0, P_DBG = 1.
  - GPIO_IN_ADDR and GPIO_OUT_ADDR constants, shared with data memory and the bench.
- One sub-module: dmem_arb_pick, a combinational 2-way picker taking (req, last_gnt, rr_mode, force1) and returning the one-hot grant.
- Lock FSM, counters and read-return registers live in dmem_arbiter.

Test Plan:
- Single read: m0 reads addr 0x10 with memory word 4 = 0xDEADBEEF -> m0_gnt in the same cycle, mem_re = 1, mem_addr = 0x10; next cycle m0_rvalid = 1, m0_rdata = 0xDEADBEEF; m1_rvalid stays 0.
- Fixed-priority starvation: RR_MODE = 0, STARVE_LIMIT = 3, both ports request continuously -> grant sequence 0,0,0,1,0,0,0,1.
- Round-robin: RR_MODE = 1, both request continuously from reset -> grants alternate 0,1,0,1; a lone m1 request is granted immediately.
- Lock: m1 writes 0x55 to 0x20 with lock, then reads 0x20 with lock, while m0 requests throughout -> m0_gnt = 0 for both cycles; m1 read returns 0x55; m0 is granted the cycle after m1 drops lock.
- GPIO passthrough: m0 writes 0xA5 to 0xFFFFFFFC -> mem_we = 1, mem_addr = 0xFFFFFFFC; gpio_out = 0xA5 after the edge; m0 reading 0xFFFFFFF8 with gpio_in = 0x3C returns 0x3C.
- Reset mid-lock: assert rst_n low during LOCK0 with a read outstanding -> gnt, mem_we and rvalid are 0 immediately; after release the state is ARB and m1 is grantable in the first cycle.
